// File: rtl/riscv_mem_loader.sv
// riscv_mem_loader
//   Host-side loader placed in front of the RISC-V core. It decodes a byte
//   stream of commands into single-cycle instruction/data memory write
//   strobes, performs data-memory reads (returned as 4 bytes, LSB first),
//   and controls the core reset so programs can be loaded while it is halted.
//
//   Commands: 0x01 WR_INS addr d0..d3 | 0x02 WR_DAT addr d0..d3 |
//             0x03 RD_DAT addr        | 0x04 RUN | 0x05 HALT
//
//   Optional feature macro: LOADER_ACK_EN
//     defined   -> every write and every RUN/HALT answers with one 0xA5 byte
//     undefined -> writes and RUN/HALT produce no tx traffic
//
// Parameters:
//   RD_LAT  cycles from read_data/addr_data asserted to sampling dato_data (1-7)
//   ADDR_W  memory address width
//
// Ports:
//   clock, reset_n          clock, synchronous active-low reset
//   rx_data/valid/ready     command/payload byte input (valid/ready handshake)
//   tx_data/valid/ready     response byte output (valid/ready handshake)
//   core_reset_n            core reset, low = halted
//   write_ins, addr_ins, dati_ins             instruction-memory write port
//   write_data, read_data, addr_data,
//   dati_data, dato_data                      data-memory access port
//   cmd_err                 one-cycle pulse on an unknown command byte
module riscv_mem_loader #(
    parameter int RD_LAT = 2,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              core_reset_n,
    output logic              write_ins,
    output logic [ADDR_W-1:0] addr_ins,
    output logic [31:0]       dati_ins,
    output logic              write_data,
    output logic              read_data,
    output logic [ADDR_W-1:0] addr_data,
    output logic [31:0]       dati_data,
    input  logic [31:0]       dato_data,
    output logic              cmd_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_RDWAIT = 3'd4;
    localparam logic [2:0] S_RDSEND = 3'd5;
`ifdef LOADER_ACK_EN
    localparam logic [2:0] S_ACK    = 3'd6;
`endif

    // Low two bits of the accepted command byte identify the packet type.
    localparam logic [1:0] CMD_INS = 2'd1;
    localparam logic [1:0] CMD_DAT = 2'd2;
    localparam logic [1:0] CMD_RD  = 2'd3;

    logic [2:0]        state_q, state_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [2:0]        lat_q, lat_d;
    logic [31:0]       sreg_q, sreg_d;
    logic [1:0]        tcnt_q, tcnt_d;
    logic              core_q, core_d;
    logic              err_q, err_d;

    logic rx_fire;
    logic tx_fire;

    // rx_ready is forced low while reset is asserted so no byte is taken
    // in the reset cycle.
    assign rx_ready = reset_n && ((state_q == S_IDLE) || (state_q == S_ADDR) ||
                                  (state_q == S_DATA));
    assign rx_fire  = rx_valid && rx_ready;
    assign tx_fire  = tx_valid && tx_ready;

`ifdef LOADER_ACK_EN
    assign tx_valid = (state_q == S_RDSEND) || (state_q == S_ACK);
    assign tx_data  = (state_q == S_ACK) ? 8'hA5 : sreg_q[7:0];
`else
    assign tx_valid = (state_q == S_RDSEND);
    assign tx_data  = sreg_q[7:0];
`endif

    assign write_ins    = (state_q == S_WRITE) && (cmd_q == CMD_INS);
    assign write_data   = (state_q == S_WRITE) && (cmd_q == CMD_DAT);
    assign read_data    = (state_q == S_RDWAIT);
    assign addr_ins     = addr_q;
    assign addr_data    = addr_q;
    assign dati_ins     = word_q;
    assign dati_data    = word_q;
    assign core_reset_n = core_q;
    assign cmd_err      = err_q;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        word_d  = word_q;
        bcnt_d  = bcnt_q;
        lat_d   = lat_q;
        sreg_d  = sreg_q;
        tcnt_d  = tcnt_q;
        core_d  = core_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    case (rx_data)
                        8'h01, 8'h02, 8'h03: begin
                            cmd_d   = rx_data[1:0];
                            state_d = S_ADDR;
                        end
                        8'h04: begin
                            core_d = 1'b1;
`ifdef LOADER_ACK_EN
                            state_d = S_ACK;
`endif
                        end
                        8'h05: begin
                            core_d = 1'b0;
`ifdef LOADER_ACK_EN
                            state_d = S_ACK;
`endif
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_ADDR: begin
                if (rx_fire) begin
                    addr_d = ADDR_W'(rx_data);
                    if (cmd_q == CMD_RD) begin
                        // Loaded with RD_LAT-1 so read_data stays high for
                        // exactly RD_LAT cycles, sampling on the last one.
                        lat_d   = 3'(RD_LAT - 1);
                        state_d = S_RDWAIT;
                    end else begin
                        bcnt_d  = 2'd0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_fire) begin
                    word_d[{bcnt_q, 3'b000} +: 8] = rx_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
`ifdef LOADER_ACK_EN
                state_d = S_ACK;
`else
                state_d = S_IDLE;
`endif
            end
            S_RDWAIT: begin
                if (lat_q == 3'd0) begin
                    sreg_d  = dato_data;
                    tcnt_d  = 2'd0;
                    state_d = S_RDSEND;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            S_RDSEND: begin
                if (tx_fire) begin
                    sreg_d = {8'h00, sreg_q[31:8]};
                    tcnt_d = tcnt_q + 2'd1;
                    if (tcnt_q == 2'd3) begin
                        state_d = S_IDLE;
                    end
                end
            end
`ifdef LOADER_ACK_EN
            S_ACK: begin
                if (tx_fire) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cmd_q   <= 2'd0;
            addr_q  <= '0;
            word_q  <= 32'h0;
            bcnt_q  <= 2'd0;
            lat_q   <= 3'd0;
            sreg_q  <= 32'h0;
            tcnt_q  <= 2'd0;
            core_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            bcnt_q  <= bcnt_d;
            lat_q   <= lat_d;
            sreg_q  <= sreg_d;
            tcnt_q  <= tcnt_d;
            core_q  <= core_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_riscv_mem_loader.sv
module tb_riscv_mem_loader;

    localparam int RD_LAT = 3;
    localparam int ADDR_W = 8;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              core_reset_n;
    logic              write_ins;
    logic [ADDR_W-1:0] addr_ins;
    logic [31:0]       dati_ins;
    logic              write_data;
    logic              read_data;
    logic [ADDR_W-1:0] addr_data;
    logic [31:0]       dati_data;
    logic [31:0]       dato_data;
    logic              cmd_err;

    always #5 clock = ~clock;

    riscv_mem_loader #(.RD_LAT(RD_LAT), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .core_reset_n(core_reset_n),
        .write_ins(write_ins), .addr_ins(addr_ins), .dati_ins(dati_ins),
        .write_data(write_data), .read_data(read_data), .addr_data(addr_data),
        .dati_data(dati_data), .dato_data(dato_data), .cmd_err(cmd_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: expected write events, expected tx bytes, memory image.
    typedef struct {
        bit          is_ins;
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wr_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] ref_mem[256];
    bit          ref_core = 1'b0;
    int          exp_err = 0;
    int          seen_err = 0;

    function automatic logic [31:0] init_word(input int a);
        return (32'(a) * 32'h01010101) ^ 32'hC3A50F1E;
    endfunction

    // Environment data SRAM: only presents valid data once read_data has been
    // held for RD_LAT cycles; otherwise it drives a poison word.
    logic [31:0] sram[256];
    bit          sram_wr[256];
    int          rd_cnt = 0;

    always @(posedge clock) begin
        rd_cnt <= read_data ? rd_cnt + 1 : 0;
        if (write_data) begin
            sram[addr_data]    <= dati_data;
            sram_wr[addr_data] <= 1'b1;
        end
    end

    assign dato_data = (read_data && rd_cnt == RD_LAT - 1) ?
                       (sram_wr[addr_data] ? sram[addr_data] : init_word(int'(addr_data))) :
                       32'h0BAD0BAD;

    // tx sink with random back-pressure, changed just after each rising edge.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1 tx_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an output.
    wr_t        mon_e;
    int         rd_run = 0;
    bit         stall = 1'b0;
    logic [7:0] stall_data;

    always @(negedge clock) begin
        if (reset_n) begin
            if (write_ins || write_data) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", {30'b0, write_ins, write_data}, 32'h0);
                end else begin
                    mon_e = wr_q.pop_front();
                    chk("write_kind", {30'b0, write_ins, write_data},
                        mon_e.is_ins ? 32'h2 : 32'h1);
                    chk("write_addr", mon_e.is_ins ? 32'(addr_ins) : 32'(addr_data),
                        32'(mon_e.addr));
                    chk("write_word", mon_e.is_ins ? dati_ins : dati_data, mon_e.data);
                end
            end
            if (stall) begin
                chk("tx_stall_valid", 32'(tx_valid), 32'h1);
                chk("tx_stall_data", 32'(tx_data), 32'(stall_data));
            end
            stall      = tx_valid && !tx_ready;
            stall_data = tx_data;
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    chk("unexpected_tx", 32'h100 | 32'(tx_data), 32'h0);
                end else begin
                    chk("tx_byte", 32'(tx_data), 32'(tx_q.pop_front()));
                end
            end
            if (read_data) begin
                rd_run++;
            end else if (rd_run != 0) begin
                chk("read_data_len", 32'(rd_run), 32'(RD_LAT));
                rd_run = 0;
            end
            if (cmd_err) seen_err++;
        end else begin
            stall  = 1'b0;
            rd_run = 0;
        end
    end

    // Stimulus: called and returns on a falling edge; returns on the falling
    // edge right after the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        repeat ($urandom_range(0, 2)) @(negedge clock);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (!rx_ready) begin
            chk("rx_accept_timeout", 32'h0, 32'h1);
            rx_valid = 1'b0;
            return;
        end
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic do_write(input bit ins, input logic [7:0] a, input logic [31:0] d);
        wr_t e;
        e.is_ins = ins;
        e.addr   = a;
        e.data   = d;
        send_byte(ins ? 8'h01 : 8'h02);
        send_byte(a);
        for (int k = 0; k < 3; k++) send_byte(d[8*k +: 8]);
        wr_q.push_back(e);
        if (!ins) ref_mem[a] = d;
`ifdef LOADER_ACK_EN
        tx_q.push_back(8'hA5);
`endif
        send_byte(d[31:24]);
        chk("core_hold", 32'(core_reset_n), 32'(ref_core));
    endtask

    task automatic do_read(input logic [7:0] a);
        logic [31:0] w;
        w = ref_mem[a];
        send_byte(8'h03);
        for (int k = 0; k < 4; k++) tx_q.push_back(w[8*k +: 8]);
        send_byte(a);
    endtask

    task automatic do_ctl(input bit run);
`ifdef LOADER_ACK_EN
        tx_q.push_back(8'hA5);
`endif
        send_byte(run ? 8'h04 : 8'h05);
        ref_core = run;
        chk(run ? "core_run" : "core_halt", 32'(core_reset_n), 32'(ref_core));
    endtask

    task automatic do_bad(input logic [7:0] b);
        send_byte(b);
        exp_err++;
        chk("cmd_err_pulse", 32'(cmd_err), 32'h1);
        @(negedge clock);
        chk("cmd_err_single", 32'(cmd_err), 32'h0);
    endtask

    task automatic drain();
        int n = 0;
        while ((tx_q.size() != 0 || wr_q.size() != 0) && n < 5000) begin
            @(negedge clock);
            n++;
        end
        chk("drain_tx_q", 32'(tx_q.size()), 32'h0);
        chk("drain_wr_q", 32'(wr_q.size()), 32'h0);
        repeat (2) @(negedge clock);
    endtask

    task automatic chk_reset_outputs(input logic exp_rx_ready);
        chk("rst_rx_ready", 32'(rx_ready), 32'(exp_rx_ready));
        chk("rst_core", 32'(core_reset_n), 32'h0);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_strobes", {29'b0, write_ins, write_data, read_data}, 32'h0);
        chk("rst_addr", {16'b0, addr_ins, addr_data}, 32'h0);
        chk("rst_dati_ins", dati_ins, 32'h0);
        chk("rst_dati_data", dati_data, 32'h0);
        chk("rst_cmd_err", 32'(cmd_err), 32'h0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clock);
        chk_reset_outputs(1'b0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("idle_rx_ready", 32'(rx_ready), 32'h1);

        do_write(1'b1, 8'h10, 32'h00000013);
        do_write(1'b0, 8'hFF, 32'hDEADBEEF);
        do_read(8'hFF);
        drain();
        do_ctl(1'b1);
        do_ctl(1'b0);
        do_bad(8'h7E);
        do_write(1'b1, 8'h11, 32'h00100093);
        do_read(8'h42);
        drain();

        // Abort mid-packet: no write may appear, everything returns to reset.
        send_byte(8'h01);
        send_byte(8'h20);
        send_byte(8'hAA);
        reset_n = 1'b0;
        ref_core = 1'b0;
        @(negedge clock);
        chk_reset_outputs(1'b0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_abort_rx_ready", 32'(rx_ready), 32'h1);
        repeat (6) @(negedge clock);

        for (int p = 0; p < 60; p++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0: do_write(1'b1, 8'($urandom), $urandom);
                1: do_write(1'b0, 8'($urandom_range(0, 15)), $urandom);
                2: do_read(8'($urandom_range(0, 15)));
                3: do_ctl(1'b1);
                4: do_ctl(1'b0);
                default: do_bad(8'($urandom_range(6, 255)));
            endcase
        end
        drain();
        chk("cmd_err_count", 32'(seen_err), 32'(exp_err));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
